// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared state encodings and constants for the fetch/data bus arbiter
//
// Contents:
//   arb_state_t          arbiter FSM state encoding
//   ZeroWord             all-zero data word (timeout read data, reset value)
//   ARB_DEFAULT_TIMEOUT  default bus-ack wait limit in cycles
//   ARB_CNT_W            width of the timeout counter (covers 1..255)
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_IF_BUSY  = 2'd1,
        ARB_DM_BUSY  = 2'd2,
        ARB_IF_DRAIN = 2'd3
    } arb_state_t;

    localparam logic [31:0] ZeroWord            = 32'h0000_0000;
    localparam int          ARB_DEFAULT_TIMEOUT = 255;
    localparam int          ARB_CNT_W           = 8;

endpackage

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single-bus arbiter between instruction fetch and data memory stages
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req_i/if_addr_i       fetch request (level) and address
//   if_flush_i               cancels the pending or in-flight fetch
//   if_ack_o/if_rdata_o      one-cycle fetch completion and instruction word
//   dm_req_i/dm_we_i/...     data request (level), store flag, address, store data, byte enables
//   dm_ack_o/dm_rdata_o      one-cycle data completion and load data
//   stallreq_if_o/_mem_o     combinational stall requests to the pipeline control unit
//   bus_req_o/bus_*_o        registered bus command, held constant while a cycle is active
//   bus_ack_i/bus_rdata_i    single-cycle bus completion and read data
//   timeout_o                sticky bus-timeout flag, cleared only by rst
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = ARB_DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    input  logic [3:0]        dm_sel_i,
    output logic              dm_ack_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              stallreq_if_o,
    output logic              stallreq_mem_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic [3:0]        bus_sel_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              timeout_o
);

    // The counter holds the number of completed busy cycles without an ack,
    // so the last allowed busy cycle is the one where it reads TIMEOUT-1.
    localparam logic [ARB_CNT_W-1:0] CNT_LAST = ARB_CNT_W'(TIMEOUT - 1);

    arb_state_t           state, state_d;
    logic [ARB_CNT_W-1:0] cnt, cnt_d;
    logic                 bus_req_d, bus_we_d;
    logic [ADDR_W-1:0]    bus_addr_d;
    logic [DATA_W-1:0]    bus_wdata_d;
    logic [3:0]           bus_sel_d;
    logic                 if_ack_d, dm_ack_d, timeout_d;
    logic [DATA_W-1:0]    if_rdata_d, dm_rdata_d;
    logic                 timed_out;

    assign stallreq_if_o  = if_req_i & ~if_ack_o;
    assign stallreq_mem_o = dm_req_i & ~dm_ack_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            cnt         <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_sel_o   <= 4'h0;
            if_ack_o    <= 1'b0;
            dm_ack_o    <= 1'b0;
            if_rdata_o  <= DATA_W'(ZeroWord);
            dm_rdata_o  <= DATA_W'(ZeroWord);
            timeout_o   <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            bus_req_o   <= bus_req_d;
            bus_we_o    <= bus_we_d;
            bus_addr_o  <= bus_addr_d;
            bus_wdata_o <= bus_wdata_d;
            bus_sel_o   <= bus_sel_d;
            if_ack_o    <= if_ack_d;
            dm_ack_o    <= dm_ack_d;
            if_rdata_o  <= if_rdata_d;
            dm_rdata_o  <= dm_rdata_d;
            timeout_o   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        bus_req_d   = bus_req_o;
        bus_we_d    = bus_we_o;
        bus_addr_d  = bus_addr_o;
        bus_wdata_d = bus_wdata_o;
        bus_sel_d   = bus_sel_o;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_o;
        dm_rdata_d  = dm_rdata_o;
        timeout_d   = timeout_o;
        timed_out   = (cnt == CNT_LAST);

        case (state)
            ARB_IDLE: begin
                // A requester whose ack is high this cycle is still holding
                // req for the completed access, so it must not be regranted.
                if (dm_req_i && !dm_ack_o) begin
                    state_d     = ARB_DM_BUSY;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = dm_we_i;
                    bus_addr_d  = dm_addr_i;
                    bus_wdata_d = dm_wdata_i;
                    bus_sel_d   = dm_sel_i;
                end else if (if_req_i && !if_ack_o && !if_flush_i) begin
                    state_d    = ARB_IF_BUSY;
                    cnt_d      = '0;
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_addr_d = if_addr_i;
                    bus_sel_d  = 4'hF;
                end
            end

            ARB_DM_BUSY: begin
                if (bus_ack_i) begin
                    state_d   = ARB_IDLE;
                    bus_req_d = 1'b0;
                    dm_ack_d  = 1'b1;
                    if (!bus_we_o) begin
                        dm_rdata_d = bus_rdata_i;
                    end
                end else if (timed_out) begin
                    state_d    = ARB_IDLE;
                    bus_req_d  = 1'b0;
                    dm_ack_d   = 1'b1;
                    dm_rdata_d = DATA_W'(ZeroWord);
                    timeout_d  = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            ARB_IF_BUSY: begin
                if (bus_ack_i) begin
                    state_d   = ARB_IDLE;
                    bus_req_d = 1'b0;
                    if (!if_flush_i) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus_rdata_i;
                    end
                end else if (timed_out) begin
                    state_d   = ARB_IDLE;
                    bus_req_d = 1'b0;
                    timeout_d = 1'b1;
                    if (!if_flush_i) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = DATA_W'(ZeroWord);
                    end
                end else begin
                    // A flushed fetch keeps its bus cycle running so the bus
                    // protocol stays intact; only the result is discarded.
                    if (if_flush_i) begin
                        state_d = ARB_IF_DRAIN;
                    end
                    cnt_d = cnt + 1'b1;
                end
            end

            ARB_IF_DRAIN: begin
                if (bus_ack_i) begin
                    state_d   = ARB_IDLE;
                    bus_req_d = 1'b0;
                end else if (timed_out) begin
                    state_d   = ARB_IDLE;
                    bus_req_d = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            default: begin
                state_d   = ARB_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_flush_i = 1'b0;
    logic        if_ack_o;
    logic [31:0] if_rdata_o;
    logic        dm_req_i = 1'b0;
    logic        dm_we_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_wdata_i = '0;
    logic [3:0]  dm_sel_i = 4'h0;
    logic        dm_ack_o;
    logic [31:0] dm_rdata_o;
    logic        stallreq_if_o;
    logic        stallreq_mem_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        timeout_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] if_q[$];
    logic [31:0] dm_q[$];
    logic [31:0] last_dm_rdata = '0;

    logic        resp_en = 1'b1;
    int          ack_delay = 2;
    logic        inject_ack = 1'b0;
    int          busy_cnt = 0;

    mem_bus_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_i      (if_req_i),
        .if_addr_i     (if_addr_i),
        .if_flush_i    (if_flush_i),
        .if_ack_o      (if_ack_o),
        .if_rdata_o    (if_rdata_o),
        .dm_req_i      (dm_req_i),
        .dm_we_i       (dm_we_i),
        .dm_addr_i     (dm_addr_i),
        .dm_wdata_i    (dm_wdata_i),
        .dm_sel_i      (dm_sel_i),
        .dm_ack_o      (dm_ack_o),
        .dm_rdata_o    (dm_rdata_o),
        .stallreq_if_o (stallreq_if_o),
        .stallreq_mem_o(stallreq_mem_o),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_sel_o     (bus_sel_o),
        .bus_ack_i     (bus_ack_i),
        .bus_rdata_i   (bus_rdata_i),
        .timeout_o     (timeout_o)
    );

    always #5 clk = ~clk;

    // Memory contents seen by the bus model; address 0x40 holds 0x3C01_1234.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return a ^ 32'h3C01_1274;
    endfunction

    // Bus slave: acks ack_delay cycles after bus_req_o is first seen high.
    initial begin
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (resp_en && bus_req_o && busy_cnt == ack_delay) begin
                bus_ack_i   = 1'b1;
                bus_rdata_i = mem_model(bus_addr_o);
                busy_cnt    = 0;
            end else begin
                bus_ack_i   = inject_ack;
                bus_rdata_i = inject_ack ? 32'hDEAD_BEEF : 32'h0;
                if (bus_req_o) busy_cnt++;
                else busy_cnt = 0;
            end
        end
    end

    // One clock; every ack pulse is matched against the scoreboard queues.
    task automatic tick();
        logic [31:0] exp;
        @(posedge clk);
        #1;
        if (if_ack_o) begin
            checks++;
            if (if_q.size() == 0) begin
                errors++;
                $display("FAIL if_ack_unexpected: got if_ack_o with rdata=%h, required no ack", if_rdata_o);
            end else begin
                exp = if_q.pop_front();
                if (if_rdata_o !== exp) begin
                    errors++;
                    $display("FAIL if_rdata: got %h, required %h", if_rdata_o, exp);
                end
            end
        end
        if (dm_ack_o) begin
            checks++;
            if (dm_q.size() == 0) begin
                errors++;
                $display("FAIL dm_ack_unexpected: got dm_ack_o with rdata=%h, required no ack", dm_rdata_o);
            end else begin
                exp = dm_q.pop_front();
                if (dm_rdata_o !== exp) begin
                    errors++;
                    $display("FAIL dm_rdata: got %h, required %h", dm_rdata_o, exp);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus_req_o, bus_we_o, if_ack_o, dm_ack_o, timeout_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got req/we/ifack/dmack/to=%b, required 00000",
                     {bus_req_o, bus_we_o, if_ack_o, dm_ack_o, timeout_o});
        end
        checks++;
        if ({bus_addr_o, bus_wdata_o, bus_sel_o} !== 68'h0) begin
            errors++;
            $display("FAIL reset_bus_cmd: got addr=%h wdata=%h sel=%h, required all 0",
                     bus_addr_o, bus_wdata_o, bus_sel_o);
        end
        checks++;
        if ({if_rdata_o, dm_rdata_o} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: got if=%h dm=%h, required 0", if_rdata_o, dm_rdata_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lone_fetch();
        int n;
        bit done;
        ack_delay = 2;
        if_addr_i = 32'h0000_0040;
        if_req_i  = 1'b1;
        if_q.push_back(32'h3C01_1234);
        #1;
        checks++;
        if (stallreq_if_o !== 1'b1) begin
            errors++;
            $display("FAIL fetch_stall_pending: got %b, required 1", stallreq_if_o);
        end
        tick();
        checks++;
        if ({bus_req_o, bus_we_o, bus_addr_o, bus_sel_o} !== {1'b1, 1'b0, 32'h40, 4'hF}) begin
            errors++;
            $display("FAIL fetch_cmd: got req=%b we=%b addr=%h sel=%h, required 1 0 00000040 f",
                     bus_req_o, bus_we_o, bus_addr_o, bus_sel_o);
        end
        n = 1;
        done = 1'b0;
        while (!done && n < 20) begin
            tick();
            n++;
            if (if_ack_o) done = 1'b1;
        end
        checks++;
        if (!done || n != 4) begin
            errors++;
            $display("FAIL fetch_latency: got ack=%b after %0d cycles, required ack after 4", done, n);
        end
        checks++;
        if (stallreq_if_o !== 1'b0) begin
            errors++;
            $display("FAIL fetch_stall_release: got %b, required 0", stallreq_if_o);
        end
        if_req_i = 1'b0;
        tick();
        checks++;
        if (if_ack_o !== 1'b0 || bus_req_o !== 1'b0) begin
            errors++;
            $display("FAIL fetch_single_pulse: got if_ack=%b bus_req=%b, required 0 0", if_ack_o, bus_req_o);
        end
    endtask

    task automatic test_contention();
        ack_delay  = 0;
        dm_we_i    = 1'b0;
        dm_addr_i  = 32'h100;
        dm_wdata_i = 32'h0;
        dm_sel_i   = 4'hF;
        dm_req_i   = 1'b1;
        if_addr_i  = 32'h44;
        if_req_i   = 1'b1;
        last_dm_rdata = mem_model(32'h100);
        dm_q.push_back(last_dm_rdata);
        if_q.push_back(mem_model(32'h44));
        tick();
        checks++;
        if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h100 || bus_we_o !== 1'b0) begin
            errors++;
            $display("FAIL contention_dm_first: got req=%b addr=%h we=%b, required 1 00000100 0",
                     bus_req_o, bus_addr_o, bus_we_o);
        end
        tick();
        checks++;
        if (dm_ack_o !== 1'b1 || stallreq_mem_o !== 1'b0 || if_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL contention_dm_ack: got dm_ack=%b stall_mem=%b if_ack=%b, required 1 0 0",
                     dm_ack_o, stallreq_mem_o, if_ack_o);
        end
        dm_req_i = 1'b0;
        tick();
        checks++;
        if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h44 || bus_sel_o !== 4'hF) begin
            errors++;
            $display("FAIL contention_fetch_next: got req=%b addr=%h sel=%h, required 1 00000044 f",
                     bus_req_o, bus_addr_o, bus_sel_o);
        end
        tick();
        checks++;
        if (if_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL contention_fetch_ack: got %b, required 1", if_ack_o);
        end
        if_req_i = 1'b0;
        tick();
    endtask

    task automatic test_store();
        int n;
        int busy;
        bit done;
        ack_delay  = 3;
        dm_we_i    = 1'b1;
        dm_addr_i  = 32'h200;
        dm_wdata_i = 32'hCAFE_F00D;
        dm_sel_i   = 4'hF;
        dm_req_i   = 1'b1;
        dm_q.push_back(last_dm_rdata);
        n = 0;
        busy = 0;
        done = 1'b0;
        while (!done && n < 20) begin
            tick();
            n++;
            if (bus_req_o) begin
                busy++;
                checks++;
                if ({bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o} !== {1'b1, 32'h200, 32'hCAFE_F00D, 4'hF}) begin
                    errors++;
                    $display("FAIL store_cmd: got we=%b addr=%h wdata=%h sel=%h, required 1 00000200 cafef00d f",
                             bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o);
                end
            end
            if (dm_ack_o) done = 1'b1;
        end
        checks++;
        if (!done || busy != 4) begin
            errors++;
            $display("FAIL store_busy_cycles: got ack=%b busy=%0d, required 1 4", done, busy);
        end
        dm_req_i = 1'b0;
        dm_we_i  = 1'b0;
        tick();
        checks++;
        if (dm_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL store_single_pulse: got %b, required 0", dm_ack_o);
        end
    endtask

    task automatic test_flush();
        int n;
        bit done;
        bit drained;
        bit early;
        ack_delay = 3;
        if_addr_i = 32'h60;
        if_req_i  = 1'b1;
        tick();
        tick();
        if_flush_i = 1'b1;
        if_addr_i  = 32'h80;
        if_q.push_back(mem_model(32'h80));
        tick();
        if_flush_i = 1'b0;
        n = 0;
        done = 1'b0;
        drained = 1'b0;
        early = 1'b0;
        while (!done && n < 30) begin
            tick();
            n++;
            if (n == 1) begin
                checks++;
                if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h60) begin
                    errors++;
                    $display("FAIL flush_drain_hold: got req=%b addr=%h, required 1 00000060",
                             bus_req_o, bus_addr_o);
                end
            end
            if (!bus_req_o) drained = 1'b1;
            else if (bus_addr_o == 32'h80 && !drained) early = 1'b1;
            if (if_ack_o) done = 1'b1;
        end
        checks++;
        if (!done || early) begin
            errors++;
            $display("FAIL flush_refetch: got ack=%b early_grant=%b, required 1 0", done, early);
        end
        if_req_i = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        int busy;
        bit done;
        resp_en   = 1'b0;
        dm_we_i   = 1'b0;
        dm_addr_i = 32'h300;
        dm_sel_i  = 4'hF;
        dm_req_i  = 1'b1;
        last_dm_rdata = 32'h0;
        dm_q.push_back(32'h0);
        n = 0;
        busy = 0;
        done = 1'b0;
        while (!done && n < 20) begin
            tick();
            n++;
            if (bus_req_o) busy++;
            if (dm_ack_o) done = 1'b1;
        end
        checks++;
        if (!done || busy != 4 || bus_req_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: got ack=%b busy=%0d req=%b, required 1 4 0", done, busy, bus_req_o);
        end
        checks++;
        if (timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag: got %b, required 1", timeout_o);
        end
        dm_req_i  = 1'b0;
        resp_en   = 1'b1;
        ack_delay = 1;
        if_addr_i = 32'h48;
        if_req_i  = 1'b1;
        if_q.push_back(mem_model(32'h48));
        n = 0;
        done = 1'b0;
        while (!done && n < 20) begin
            tick();
            n++;
            if (if_ack_o) done = 1'b1;
        end
        if_req_i = 1'b0;
        checks++;
        if (!done || timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got ack=%b timeout=%b, required 1 1", done, timeout_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        resp_en   = 1'b0;
        dm_we_i   = 1'b0;
        dm_addr_i = 32'h400;
        dm_req_i  = 1'b1;
        tick();
        tick();
        rst      = 1'b1;
        dm_req_i = 1'b0;
        tick();
        checks++;
        if ({bus_req_o, bus_we_o, if_ack_o, dm_ack_o, timeout_o} !== 5'b0 ||
            {bus_addr_o, bus_wdata_o, bus_sel_o, if_rdata_o, dm_rdata_o} !== 132'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got req=%b we=%b to=%b addr=%h rdata=%h, required all 0",
                     bus_req_o, bus_we_o, timeout_o, bus_addr_o, dm_rdata_o);
        end
        rst = 1'b0;
        last_dm_rdata = 32'h0;
        inject_ack = 1'b1;
        tick();
        inject_ack = 1'b0;
        tick();
        checks++;
        if (if_ack_o !== 1'b0 || dm_ack_o !== 1'b0 || bus_req_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stray_ack: got if_ack=%b dm_ack=%b req=%b, required 0 0 0",
                     if_ack_o, dm_ack_o, bus_req_o);
        end
        tick();
        resp_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_contention();
        test_store();
        test_flush();
        test_timeout();
        test_reset_mid();
        checks++;
        if (if_q.size() != 0 || dm_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d if and %0d dm pending, required 0 0",
                     if_q.size(), dm_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
